// File: rtl/thread_cmd_issuer_if.sv
// Decode-side request, thread-controller command bus and status response
// for thread_cmd_issuer. "master" is the issuer; "slave" is its environment.
interface thread_cmd_issuer_if;
    // request from decode
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_act_trd;
    logic [2:0]  req_obj_trd;
    logic [31:0] req_pc;
    // command bus to thread controller
    logic        init_trd;
    logic        kill;
    logic        slp;
    logic        wake;
    logic [2:0]  act_trd;
    logic [2:0]  obj_trd;
    logic [31:0] init_pc;
    logic        stall;
    logic [7:0]  valid_trd;
    logic [2:0]  new_trd;
    logic        trd_of;
    logic        invalid_op;
    // status response
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [2:0]  rsp_new_trd;

    modport master (
        input  req_valid, req_op, req_act_trd, req_obj_trd, req_pc,
        output req_ready,
        output init_trd, kill, slp, wake, act_trd, obj_trd, init_pc,
        input  stall, valid_trd, new_trd, trd_of, invalid_op,
        output rsp_valid, rsp_status, rsp_new_trd,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_op, req_act_trd, req_obj_trd, req_pc,
        input  req_ready,
        input  init_trd, kill, slp, wake, act_trd, obj_trd, init_pc,
        output stall, valid_trd, new_trd, trd_of, invalid_op,
        input  rsp_valid, rsp_status, rsp_new_trd,
        output rsp_ready
    );
endinterface

// File: rtl/thread_cmd_issuer.sv
// thread_cmd_issuer: accepts one INIT/KILL/SLEEP/WAKE request at a time,
// pre-checks the target thread, drives a one-cycle command strobe (held off
// by stall), then returns the controller's error status as a response.
// Optional macro TRD_CMD_TIMEOUT_EN: abort with TIMEOUT after STALL_LIMIT
// consecutive stall cycles in ISSUE.
module thread_cmd_issuer #(
    parameter int STALL_LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    thread_cmd_issuer_if.master bus
);
    localparam logic [1:0] OP_INIT = 2'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;
    typedef enum logic [1:0] {ST_OK, ST_OVF, ST_INV, ST_TMO} status_t;

    if (STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_limit
        $error("STALL_LIMIT must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [2:0]  act_q, obj_q, new_q;
    logic [31:0] pc_q;
    status_t     status_q;

    logic        accept;
    logic        ld_rsp;
    status_t     ld_status;
    logic [2:0]  ld_new;
    logic [3:0]  cmd;   // one-hot by op code: [0]=INIT [1]=KILL [2]=SLEEP [3]=WAKE

`ifdef TRD_CMD_TIMEOUT_EN
    localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);
    logic [7:0] stall_cnt_q;

    // count stalled ISSUE cycles; cleared whenever a request is taken
    always_ff @(posedge clk) begin
        if (rst || accept)
            stall_cnt_q <= '0;
        else if (state_q == ISSUE && bus.stall)
            stall_cnt_q <= stall_cnt_q + 8'd1;
    end
`endif

    // next-state, strobe and response-load decode
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ld_rsp    = 1'b0;
        ld_status = ST_OK;
        ld_new    = '0;
        cmd       = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    // dead target: answer immediately, controller never sees it
                    if (bus.req_op != OP_INIT && !bus.valid_trd[bus.req_obj_trd]) begin
                        state_d   = RESP;
                        ld_rsp    = 1'b1;
                        ld_status = ST_INV;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.stall) begin
                    cmd[op_q] = 1'b1;
                    state_d   = CHECK;
                end
`ifdef TRD_CMD_TIMEOUT_EN
                else if (stall_cnt_q == LIMIT_M1) begin
                    state_d   = RESP;
                    ld_rsp    = 1'b1;
                    ld_status = ST_TMO;
                end
`endif
            end
            CHECK: begin
                state_d = RESP;
                ld_rsp  = 1'b1;
                if (bus.trd_of)
                    ld_status = ST_OVF;
                else if (bus.invalid_op)
                    ld_status = ST_INV;
                else if (op_q == OP_INIT)
                    ld_new = bus.new_trd;
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, captured request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_INIT;
            act_q    <= '0;
            obj_q    <= '0;
            pc_q     <= '0;
            status_q <= ST_OK;
            new_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus.req_op;
                act_q <= bus.req_act_trd;
                obj_q <= bus.req_obj_trd;
                pc_q  <= bus.req_pc;
            end
            if (ld_rsp) begin
                status_q <= ld_status;
                new_q    <= ld_new;
            end
        end
    end

    // strobes are masked by rst so nothing escapes in the reset cycle
    assign bus.init_trd    = cmd[0] & ~rst;
    assign bus.kill        = cmd[1] & ~rst;
    assign bus.slp         = cmd[2] & ~rst;
    assign bus.wake        = cmd[3] & ~rst;
    assign bus.act_trd     = act_q;
    assign bus.obj_trd     = obj_q;
    assign bus.init_pc     = pc_q;
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_status  = status_q;
    assign bus.rsp_new_trd = new_q;
endmodule

// File: doc/thread_cmd_issuer.md
# thread_cmd_issuer

Issues thread-management commands to the thread controller on behalf of the decode stage. It accepts one request at a time (INIT, KILL, SLEEP, WAKE) over a valid/ready handshake and pre-checks the target thread against `valid_trd`. It then drives a single-cycle command strobe, holding it off while `stall` is high. Finally it samples the controller's error flags and returns a status response. It is the initiator side of the kill/slp/wake/init_trd interface.

## Interface
- `STALL_LIMIT`, 64: stall cycles tolerated before timeout (only with `TRD_CMD_TIMEOUT_EN`); range 1..255.
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  issuer can accept a request
- `req_op`  in  2  0=INIT, 1=KILL, 2=SLEEP, 3=WAKE
- `req_act_trd`  in  3  thread issuing the command
- `req_obj_trd`  in  3  target thread (ignored for INIT)
- `req_pc`  in  32  start PC for INIT
- `init_trd` / `kill` / `slp` / `wake`  out  1 each  one-hot command strobes to thread controller
- `act_trd`  out  3  registered `req_act_trd`
- `obj_trd`  out  3  registered `req_obj_trd`
- `init_pc`  out  32  registered `req_pc`
- `stall`  in  1  controller cannot take a command this cycle
- `valid_trd`  in  8  controller's valid-thread mask
- `new_trd`  in  3  thread created by last INIT
- `trd_of`  in  1  controller overflow flag
- `invalid_op`  in  1  controller permission error flag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_status`  out  2  0=OK, 1=OVERFLOW, 2=INVALID, 3=TIMEOUT
- `rsp_new_trd`  out  3  created thread ID (valid when op=INIT and status=OK, else 0)

## Operation
- FSM states: IDLE, ISSUE, CHECK, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, register op/act/obj/pc.
  - If op≠INIT and `valid_trd[req_obj_trd]`=0, go to RESP with status INVALID; no strobe is ever driven.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Strobe for the registered op is asserted combinationally only when `stall`=0; then go to CHECK.
  - While `stall`=1 all strobes are 0 and the state holds.
  - `act_trd`, `obj_trd` and `init_pc` stay stable from ISSUE entry through CHECK.
- **CHECK** (first cycle after the strobe)
  - Capture status: `trd_of` gives OVERFLOW; else `invalid_op` gives INVALID; else OK.
  - For INIT with OK, capture `new_trd` into `rsp_new_trd`.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1; outputs stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `req_ready`=0 in every state except IDLE, so at most one command is in flight.
- At most one strobe is high in any cycle, and it is high for exactly one cycle per accepted request (except INVALID pre-check and TIMEOUT).
- Error priority when both flags are set: OVERFLOW over INVALID.

## Timing
- Reset values: all strobes 0, `act_trd`/`obj_trd`=0, `init_pc`=0, `req_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_status`=0, `rsp_new_trd`=0.
- `rst` mid-operation returns to IDLE next cycle. Any in-flight request and response are dropped, and no strobe follows.
- No-stall latency: handshake at cycle N, strobe at N+1, `rsp_valid` at N+3.
- Pre-check INVALID: `rsp_valid` at N+1.
- Each stall cycle in ISSUE adds one cycle.
- Back-to-back: the next request can be accepted the cycle after the response handshake. Minimum 4 cycles per command.

## Configuration
- `TRD_CMD_TIMEOUT_EN` defined:
  - An 8-bit counter clears on ISSUE entry and increments each ISSUE cycle with `stall`=1.
  - When it reaches `STALL_LIMIT`, go to RESP with status TIMEOUT; no strobe is driven.
- Undefined: no counter; ISSUE waits on `stall` indefinitely and status 3 is never produced.

## Test plan
- Reset, then INIT with `req_pc`=0x0000_1000 and `new_trd`=1 → `init_trd` pulses at N+1 with `init_pc`=0x1000; at N+3 `rsp_status`=0 and `rsp_new_trd`=1.
- `valid_trd`=0x03, SLEEP obj=5 → no strobe; at N+1 `rsp_status`=2 and `rsp_new_trd`=0.
- KILL act=0 obj=1 with `stall` high for 3 cycles → `kill` pulses once at N+4; `rsp_valid` at N+6.
- INIT with `trd_of`=1 in the CHECK cycle → `rsp_status`=1; with both flags set, still 1.
- Hold `rsp_ready`=0 for 5 cycles → response stable, `req_ready`=0, a second `req_valid` is not accepted; accepted the cycle after the handshake.
- With `TRD_CMD_TIMEOUT_EN`, `STALL_LIMIT`=4, permanent stall on WAKE → `rsp_status`=3 and `wake` never asserted. Assert `rst` during ISSUE → IDLE, no strobe, `rsp_valid`=0.
